// File: rtl/fpnew_divsqrt_arbiter.sv
// fpnew_divsqrt_arbiter: shares one single-in-flight divide/sqrt unit between
// NumReq requesters. Round-robin grant, valid/ready issue, and owner/tag
// tracking so that the result returns only to the requester that issued it.
// Optional macro FPNEW_DIVSQRT_ARB_PRIO_EN: requester 0 wins over round-robin.
module fpnew_divsqrt_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][1:0][Width-1:0]     req_operands_i,
  input  logic [NumReq-1:0][3:0]                req_op_i,
  input  logic [NumReq-1:0][2:0]                req_rnd_mode_i,
  input  logic [NumReq-1:0][2:0]                req_fmt_i,
  input  logic [NumReq-1:0][TagWidth-1:0]       req_tag_i,
  output logic [NumReq-1:0]                     rsp_valid_o,
  input  logic [NumReq-1:0]                     rsp_ready_i,
  output logic [Width-1:0]                      rsp_result_o,
  output logic [4:0]                            rsp_status_o,
  output logic [TagWidth-1:0]                   rsp_tag_o,
  output logic                                  unit_valid_o,
  input  logic                                  unit_ready_i,
  output logic [1:0][Width-1:0]                 unit_operands_o,
  output logic [3:0]                            unit_op_o,
  output logic [2:0]                            unit_rnd_mode_o,
  output logic [2:0]                            unit_fmt_o,
  input  logic                                  unit_valid_i,
  output logic                                  unit_ready_o,
  input  logic [Width-1:0]                      unit_result_i,
  input  logic [4:0]                            unit_status_i,
  output logic                                  unit_flush_o,
  output logic                                  busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [TagWidth-1:0] tag_q, tag_d;

  logic [IdxW-1:0]     arb_idx, cand, sel_idx, ptr_next;
  logic [IdxW:0]       cand_sum;
  logic                arb_found, issue_vld;

  // Round-robin search from rr_ptr upward with wrap; the sum is one bit wider
  // so the wrap test works for non-power-of-two NumReq.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand_sum >= (IdxW+1)'(NumReq)) cand_sum = cand_sum - (IdxW+1)'(NumReq);
      cand = cand_sum[IdxW-1:0];
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
      if (!arb_found && (cand != '0) && req_valid_i[cand]) begin
`else
      if (!arb_found && req_valid_i[cand]) begin
`endif
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
    if (req_valid_i[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
`endif
  end

  // Issue source: locked grant while waiting for the unit, live grant otherwise.
  always_comb begin
    sel_idx   = (state_q == ISSUE) ? grant_q : arb_idx;
    issue_vld = (state_q == ISSUE) || ((state_q == IDLE) && arb_found);
    ptr_next  = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Next-state and handshake outputs; reset and flush force all valid/ready low.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    tag_d        = tag_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    unit_valid_o = 1'b0;
    unit_ready_o = 1'b0;
    if (rst_i) begin
      state_d = IDLE;
    end else if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ISSUE: begin
          unit_ready_o = 1'b1;
          if (issue_vld) begin
            unit_valid_o         = 1'b1;
            req_ready_o[sel_idx] = unit_ready_i;
            if (unit_ready_i) begin
              state_d = BUSY;
              owner_d = sel_idx;
              tag_d   = req_tag_i[sel_idx];
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
              if (sel_idx != '0) rr_ptr_d = ptr_next;
`else
              rr_ptr_d = ptr_next;
`endif
            end else begin
              state_d = ISSUE;
              grant_d = sel_idx;
            end
          end
        end
        BUSY: begin
          rsp_valid_o[owner_q] = unit_valid_i;
          unit_ready_o         = rsp_ready_i[owner_q];
          if (unit_valid_i && rsp_ready_i[owner_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Payload steering and pass-through response buses.
  always_comb begin
    unit_operands_o = req_operands_i[sel_idx];
    unit_op_o       = req_op_i[sel_idx];
    unit_rnd_mode_o = req_rnd_mode_i[sel_idx];
    unit_fmt_o      = req_fmt_i[sel_idx];
    rsp_result_o    = unit_result_i;
    rsp_status_o    = unit_status_i;
    rsp_tag_o       = tag_q;
    unit_flush_o    = flush_i;
    busy_o          = (state_q != IDLE);
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Bench for fpnew_divsqrt_arbiter: directed literal checks followed by a
// randomized run compared every cycle against a transaction-level model.
module tb_fpnew_divsqrt_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_i, flush_i;
  logic [N-1:0] req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N-1:0][1:0][W-1:0] req_operands_i;
  logic [N-1:0][3:0] req_op_i;
  logic [N-1:0][2:0] req_rnd_mode_i, req_fmt_i;
  logic [N-1:0][T-1:0] req_tag_i;
  logic [W-1:0] rsp_result_o, unit_result_i;
  logic [4:0] rsp_status_o, unit_status_i;
  logic [T-1:0] rsp_tag_o;
  logic unit_valid_o, unit_ready_i, unit_valid_i, unit_ready_o, unit_flush_o, busy_o;
  logic [1:0][W-1:0] unit_operands_o;
  logic [3:0] unit_op_o;
  logic [2:0] unit_rnd_mode_o, unit_fmt_o;

  fpnew_divsqrt_arbiter #(.NumReq(N), .Width(W), .TagWidth(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i),
    .req_rnd_mode_i(req_rnd_mode_i), .req_fmt_i(req_fmt_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o),
    .unit_rnd_mode_o(unit_rnd_mode_o), .unit_fmt_o(unit_fmt_o),
    .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o),
    .unit_result_i(unit_result_i), .unit_status_i(unit_status_i),
    .unit_flush_o(unit_flush_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester payload storage
  logic [N-1:0]   av;
  logic [W-1:0]   a_opa [N];
  logic [W-1:0]   a_opb [N];
  logic [3:0]     a_op  [N];
  logic [2:0]     a_rnd [N];
  logic [2:0]     a_fmt [N];
  logic [T-1:0]   a_tag [N];

  // Model state: -1 means none
  int m_ptr, m_lock, m_owner, g;
  logic [T-1:0] m_tag;
  logic [W-1:0] m_res;
  // Unit agent
  logic u_busy;
  int   u_cnt;
  logic [W-1:0] u_res;
  logic [4:0]   u_st;
  // Expected outputs
  logic [N-1:0] e_rrdy, e_rsp;
  logic e_uv, e_urdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_payload();
    for (int r = 0; r < N; r++) begin
      req_operands_i[r][0] = a_opa[r];
      req_operands_i[r][1] = a_opb[r];
      req_op_i[r]          = a_op[r];
      req_rnd_mode_i[r]    = a_rnd[r];
      req_fmt_i[r]         = a_fmt[r];
      req_tag_i[r]         = a_tag[r];
    end
  endtask

  // Round-robin choice by rule: first valid at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; rsp_ready_i = '0;
    unit_ready_i = 1'b0; unit_valid_i = 1'b0; unit_result_i = '0; unit_status_i = '0;
    for (int r = 0; r < N; r++) begin
      a_opa[r] = W'(64'h100 + r); a_opb[r] = W'(64'h200 + r);
      a_op[r] = 4'(r + 1); a_rnd[r] = 3'(r); a_fmt[r] = 3'(r);
      a_tag[r] = T'(8'hA0 + r);
    end
    drive_payload();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_unit_valid", unit_valid_o, 0);
    chk("rst_unit_ready", unit_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);

    // First grant after reset: requester 1, zero-cycle issue
    tick(); rst_i = 1'b0; req_valid_i = 4'b1010; unit_ready_i = 1'b1;
    #1;
    chk("d1_req_ready", req_ready_o, 4'b0010);
    chk("d1_unit_valid", unit_valid_o, 1);
    chk("d1_unit_op", unit_op_o, 4'd2);
    chk("d1_unit_opnd", unit_operands_o, {64'h201, 64'h101});
    tick(); req_valid_i = '0; unit_ready_i = 1'b0;
    #1;
    chk("d1_busy", busy_o, 1);
    chk("d1_req_ready_busy", req_ready_o, 0);

    // Result held while owner not ready
    unit_valid_i = 1'b1; unit_result_i = 64'h1234; unit_status_i = 5'h15;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("d2_rsp_valid", rsp_valid_o, 4'b0010);
      chk("d2_unit_ready", unit_ready_o, 0);
      chk("d2_rsp_tag", rsp_tag_o, 8'hA1);
      tick();
    end
    rsp_ready_i = 4'b0010;
    #1;
    chk("d2_unit_ready_hs", unit_ready_o, 1);
    chk("d2_rsp_result", rsp_result_o, 64'h1234);
    chk("d2_rsp_status", rsp_status_o, 5'h15);

    // Bubble then requester 2 stuck in ISSUE while unit not ready
    tick(); unit_valid_i = 1'b0; rsp_ready_i = '0; req_valid_i = 4'b0100; unit_ready_i = 1'b0;
    #1;
    chk("d3_idle_busy", busy_o, 0);
    chk("d3_unit_valid", unit_valid_o, 1);
    chk("d3_req_ready", req_ready_o, 0);
    tick(); req_valid_i = 4'b0101;
    #1;
    chk("d3_issue_busy", busy_o, 1);
    chk("d3_lock_op", unit_op_o, 4'd3);
    chk("d3_req_ready2", req_ready_o, 0);
    tick();
    #1;
    chk("d3_lock_op2", unit_op_o, 4'd3);
    tick(); unit_ready_i = 1'b1;
    #1;
    chk("d3_accept", req_ready_o, 4'b0100);

    // Flush during BUSY
    tick(); req_valid_i = 4'b1111; unit_ready_i = 1'b0; unit_valid_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("d4_flush_o", unit_flush_o, 1);
    chk("d4_rsp_valid", rsp_valid_o, 0);
    chk("d4_unit_ready", unit_ready_o, 0);
    chk("d4_req_ready", req_ready_o, 0);
    tick(); flush_i = 1'b0; unit_valid_i = 1'b0; unit_ready_i = 1'b1;
    #1;
    chk("d4_idle", busy_o, 0);
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
    chk("d4_rr_kept", req_ready_o, 4'b0001);
`else
    chk("d4_rr_kept", req_ready_o, 4'b1000);
`endif

    // Asynchronous reset mid-BUSY
    tick();
    #1;
    chk("d5_busy", busy_o, 1);
    #2; rst_i = 1'b1;
    #1;
    chk("d5_async_busy", busy_o, 0);
    chk("d5_async_uvalid", unit_valid_o, 0);
    chk("d5_async_rready", req_ready_o, 0);
    chk("d5_async_uready", unit_ready_o, 0);
    tick(); rst_i = 1'b0;
    #1;
    chk("d5_grant0", req_ready_o, 4'b0001);

    // Randomized phase
    tick(); rst_i = 1'b1; req_valid_i = '0; unit_ready_i = 1'b0;
    tick(); tick(); rst_i = 1'b0;
    m_ptr = 0; m_lock = -1; m_owner = -1; m_tag = '0; m_res = '0;
    av = '0; u_busy = 1'b0; u_cnt = 0; u_res = '0; u_st = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      flush_i      = ($urandom_range(0, 49) == 0);
      unit_ready_i = ($urandom_range(0, 9) < 6);
      rsp_ready_i  = N'($urandom);
      for (int r = 0; r < N; r++) begin
        if (!av[r] && $urandom_range(0, 3) == 0) begin
          av[r] = 1'b1;
          a_opa[r] = {$urandom, $urandom}; a_opb[r] = {$urandom, $urandom};
          a_op[r] = 4'($urandom); a_rnd[r] = 3'($urandom); a_fmt[r] = 3'($urandom);
          a_tag[r] = T'($urandom);
        end
      end
      req_valid_i = av;
      drive_payload();
      if (u_busy) begin
        if (u_cnt == 0) begin
          unit_valid_i = 1'b1; unit_result_i = u_res; unit_status_i = u_st;
        end else begin
          u_cnt--; unit_valid_i = 1'b0; unit_result_i = {$urandom, $urandom};
        end
      end else begin
        unit_valid_i  = ($urandom_range(0, 29) == 0);
        unit_result_i = {$urandom, $urandom}; unit_status_i = 5'($urandom);
      end
      #1;
      // Expected outputs
      e_rrdy = '0; e_rsp = '0; e_uv = 1'b0; e_urdy = 1'b0; g = -1;
      if (!flush_i) begin
        if (m_owner >= 0) begin
          e_rsp[m_owner] = unit_valid_i;
          e_urdy = rsp_ready_i[m_owner];
        end else begin
          e_urdy = 1'b1;
          g = (m_lock >= 0) ? m_lock : pick(req_valid_i, m_ptr);
          if (g >= 0) begin
            e_uv = 1'b1;
            e_rrdy[g] = unit_ready_i;
          end
        end
      end
      chk("r_req_ready", req_ready_o, e_rrdy);
      chk("r_unit_valid", unit_valid_o, e_uv);
      chk("r_unit_ready", unit_ready_o, e_urdy);
      chk("r_rsp_valid", rsp_valid_o, e_rsp);
      chk("r_flush", unit_flush_o, flush_i);
      chk("r_busy", busy_o, (m_lock >= 0) || (m_owner >= 0));
      if (e_uv) begin
        chk("r_unit_opnd", unit_operands_o, {a_opb[g], a_opa[g]});
        chk("r_unit_ctl", {unit_op_o, unit_rnd_mode_o, unit_fmt_o}, {a_op[g], a_rnd[g], a_fmt[g]});
      end
      if (e_rsp != '0) begin
        chk("r_rsp_tag", rsp_tag_o, m_tag);
        chk("r_rsp_status", rsp_status_o, u_st);
        if (e_urdy) chk("r_sb_result", rsp_result_o, m_res);
      end
      // Advance model and agents to the state after the coming edge
      if (flush_i) begin
        m_lock = -1; m_owner = -1; u_busy = 1'b0;
      end else if (m_owner >= 0) begin
        if (unit_valid_i && rsp_ready_i[m_owner]) begin
          m_owner = -1; u_busy = 1'b0;
        end
      end else if (g >= 0) begin
        if (unit_ready_i) begin
          m_owner = g; m_tag = a_tag[g]; m_res = a_opa[g] + a_opb[g];
`ifdef FPNEW_DIVSQRT_ARB_PRIO_EN
          if (g != 0) m_ptr = (g + 1) % N;
`else
          m_ptr = (g + 1) % N;
`endif
          m_lock = -1; av[g] = 1'b0;
          u_busy = 1'b1; u_cnt = $urandom_range(0, 5);
          u_res = m_res; u_st = 5'(a_op[g] ^ {2'b00, a_fmt[g]});
        end else begin
          m_lock = g;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpnew_divsqrt_arbiter.md
Name: fpnew_divsqrt_arbiter

Overview:
- Shares one multi-cycle divide/sqrt unit (single operation in flight) between NumReq independent requesters, such as several FPU lanes or cores in a cluster.
- Arbitrates requests round-robin and forwards the winner to the unit over a valid/ready handshake.
- Records the owner and tag of the in-flight operation and routes the unit's result back to that requester only.
- Sits between the requesters' operation-group dispatch and the shared divsqrt instance.

Parameters:
- NumReq, 4, number of requesters (2..16).
- Width, 64, operand/result width in bits.
- TagWidth, 8, width of the opaque per-request tag returned with the result.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  kill the in-flight operation and all pending issue.
- req_valid_i  in  NumReq  request valid, one bit per requester.
- req_ready_o  out  NumReq  request accepted, one bit per requester.
- req_operands_i  in  NumReq x 2 x Width  operands a and b.
- req_op_i  in  NumReq x 4  fpnew operation code.
- req_rnd_mode_i  in  NumReq x 3  rounding mode.
- req_fmt_i  in  NumReq x 3  destination format.
- req_tag_i  in  NumReq x TagWidth  requester tag.
- rsp_valid_o  out  NumReq  result valid, only the owner's bit can be high.
- rsp_ready_i  in  NumReq  requester accepts result.
- rsp_result_o  out  Width  result, shared bus.
- rsp_status_o  out  5  fflags (NV,DZ,OF,UF,NX), shared bus.
- rsp_tag_o  out  TagWidth  tag of the returning operation.
- unit_valid_o / unit_ready_i  out/in  1  issue handshake to the unit.
- unit_operands_o  out  2 x Width  operands to the unit.
- unit_op_o  out  4  operation to the unit.
- unit_rnd_mode_o  out  3  rounding mode to the unit.
- unit_fmt_o  out  3  destination format to the unit.
- unit_valid_i / unit_ready_o  in/out  1  result handshake from the unit.
- unit_result_i  in  Width  result from the unit.
- unit_status_i  in  5  fflags from the unit.
- unit_flush_o  out  1  kill to the unit; equals flush_i.
- busy_o  out  1  an operation is being issued or is in flight.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner_q=0, tag_q=0, all valid/ready outputs 0, busy_o=0.
- State IDLE:
  - Combinational grant g = first index with req_valid_i set, searching from rr_ptr upward and wrapping.
  - unit_valid_o=1 and unit_* fields driven from requester g; req_ready_o[g]=unit_ready_i.
  - Zero-cycle issue latency.
  - On handshake: owner_q<=g, tag_q<=req_tag_i[g], rr_ptr<=(g+1) mod NumReq, go to BUSY.
  - If unit_ready_i=0: grant_q<=g, go to ISSUE.
- State ISSUE:
  - Grant locked to grant_q. No re-arbitration even if a higher-ranked request arrives.
  - Requester must hold valid and payload stable until accepted.
  - On handshake: same updates as IDLE, go to BUSY.
- State BUSY:
  - req_ready_o all 0.
  - rsp_valid_o[owner_q]=unit_valid_i; unit_ready_o=rsp_ready_i[owner_q].
  - rsp_result_o, rsp_status_o, rsp_tag_o are pass-through (tag from tag_q).
  - Response handshake: go to IDLE. Arbitration restarts the following cycle, giving a 1-cycle bubble.
- Unit result while IDLE or ISSUE: dropped; unit_ready_o=1 in those states.
- busy_o=1 in ISSUE and BUSY.
- flush_i, highest priority:
  - All valid and ready outputs forced to 0 in the same cycle; unit_flush_o=1.
  - Next state=IDLE; rr_ptr is not changed.
- Requesters with no operation in flight never see rsp_valid_o.
- rsp_* buses may carry stale values when no rsp_valid_o bit is high.

Optional Feature:
- Macro FPNEW_DIVSQRT_ARB_PRIO_EN.
- When defined: requester 0 has strict priority over round-robin. It is granted whenever its valid is high in IDLE. rr_ptr is then still used among requesters 1..NumReq-1 and advances only on their grants.
- When undefined: pure round-robin across all requesters as above.

Test Plan:
- After reset, req_valid_i=4'b1010, unit_ready_i=1 -> requester 1 issued in cycle 0 with req_ready_o=4'b0010; rr_ptr becomes 2.
- All 4 requesters valid continuously, unit completes after 10 cycles -> grant order 0,1,2,3,0. Each result appears only on the matching rsp_valid_o bit, with the matching tag.
- unit_ready_i=0 for 3 cycles while requester 2 is in ISSUE and requester 0 raises valid -> grant stays 2. It is accepted in cycle 3 and no other req_ready_o is high.
- Unit result arrives with rsp_ready_i[owner]=0 for 5 cycles -> unit_ready_o=0 and rsp_valid_o held. The handshake completes in the cycle ready rises, and the next issue happens one cycle later.
- flush_i pulsed during BUSY -> unit_flush_o=1 that cycle, no rsp_valid_o, state returns to IDLE, rr_ptr unchanged.
- rst_i asserted mid-BUSY -> outputs go to 0 immediately, asynchronously, and the next grant starts from requester 0.
- With FPNEW_DIVSQRT_ARB_PRIO_EN defined and requesters 0 and 3 continuously valid -> requester 0 is granted every operation.
